// File: rtl/tetris_input_ctrl.sv
// Player-input front end: joystick zone FSM with hysteresis, button debounce,
// and single-cycle move/press pulses with delayed auto-shift repeat.
module tetris_input_ctrl #(
    parameter int                 ADC_W        = 12,
    parameter int                 LOW_TH       = 1000,
    parameter int                 HIGH_TH      = 2300,
    parameter int                 HYST         = 100,
    parameter int                 NUM_BTN      = 2,
    parameter int                 DEBOUNCE_CYC = 500000,
    parameter int                 DAS_DELAY    = 12500000,
    parameter int                 DAS_REPEAT   = 2500000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADC_W-1:0]   adc_value,
    input  logic               adc_valid,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               move_left,
    output logic               move_right,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [1:0]         zone,
    output logic               led_red,
    output logic               led_green
);

    localparam int DAS_MAX = (DAS_DELAY > DAS_REPEAT) ? DAS_DELAY : DAS_REPEAT;
    localparam int DAS_W   = $clog2(DAS_MAX + 1);
    localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [DAS_W-1:0] DAS_LOAD   = DAS_W'(DAS_DELAY);
    localparam logic [DAS_W-1:0] DAS_RELOAD = DAS_W'(DAS_REPEAT);
    localparam logic [DAS_W-1:0] DAS_ONE    = DAS_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);

    localparam logic [ADC_W-1:0] LOW_V        = ADC_W'(LOW_TH);
    localparam logic [ADC_W-1:0] HIGH_V       = ADC_W'(HIGH_TH);
    localparam logic [ADC_W-1:0] RIGHT_EXIT_V = ADC_W'(HIGH_TH - HYST);
    localparam logic [ADC_W-1:0] LEFT_EXIT_V  = ADC_W'(LOW_TH + HYST);

    typedef enum logic [1:0] {
        ZONE_CENTER = 2'b00,
        ZONE_LEFT   = 2'b01,
        ZONE_RIGHT  = 2'b10
    } zone_t;

    zone_t            zone_q, zone_d;
    logic             dir_enter;
    logic [DAS_W-1:0] dir_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zone_q <= ZONE_CENTER;
        end else begin
            zone_q <= zone_d;
        end
    end

    always_comb begin
        zone_d = zone_q;
        if (adc_valid) begin
            unique case (zone_q)
                ZONE_CENTER: begin
                    if (adc_value > HIGH_V)     zone_d = ZONE_RIGHT;
                    else if (adc_value < LOW_V) zone_d = ZONE_LEFT;
                end
                ZONE_RIGHT: begin
                    if (adc_value < LOW_V)              zone_d = ZONE_LEFT;
                    else if (adc_value <= RIGHT_EXIT_V) zone_d = ZONE_CENTER;
                end
                ZONE_LEFT: begin
                    if (adc_value > HIGH_V)            zone_d = ZONE_RIGHT;
                    else if (adc_value >= LEFT_EXIT_V) zone_d = ZONE_CENTER;
                end
                default: zone_d = ZONE_CENTER;
            endcase
        end
        dir_enter = (zone_d != zone_q) && (zone_d != ZONE_CENTER);
    end

    assign zone      = zone_q;
    assign led_red   = (zone_q == ZONE_RIGHT);
    assign led_green = (zone_q == ZONE_LEFT);

    // One counter serves both directions; a LEFT<->RIGHT switch counts as a fresh entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_cnt    <= '0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
        end else begin
            move_left  <= 1'b0;
            move_right <= 1'b0;
            if (dir_enter) begin
                move_left  <= (zone_d == ZONE_LEFT);
                move_right <= (zone_d == ZONE_RIGHT);
                dir_cnt    <= DAS_LOAD;
            end else if (zone_d == ZONE_CENTER) begin
                dir_cnt <= '0;
            end else if (dir_cnt == DAS_ONE) begin
                move_left  <= (zone_d == ZONE_LEFT);
                move_right <= (zone_d == ZONE_RIGHT);
                dir_cnt    <= DAS_RELOAD;
            end else begin
                dir_cnt <= dir_cnt - DAS_ONE;
            end
        end
    end

    logic [NUM_BTN-1:0] sync1, sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [DB_W-1:0]  db_cnt;
        logic [DAS_W-1:0] rep_cnt;
        logic             level_q, press_q;
        logic             toggle, rise, fall;

        assign toggle = (sync2[i] != level_q) && (db_cnt == DB_LAST);
        assign rise   = toggle && !level_q;
        assign fall   = toggle && level_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_cnt  <= '0;
                rep_cnt <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
            end else begin
                press_q <= rise;
                if (sync2[i] == level_q || toggle) begin
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_ONE;
                end
                if (toggle) begin
                    level_q <= ~level_q;
                end
                // Repeat timer runs only while a repeat-enabled button stays debounced-high.
                if (rise && REPEAT_MASK[i]) begin
                    rep_cnt <= DAS_LOAD;
                end else if (!level_q || fall || !REPEAT_MASK[i]) begin
                    rep_cnt <= '0;
                end else if (rep_cnt == DAS_ONE) begin
                    press_q <= 1'b1;
                    rep_cnt <= DAS_RELOAD;
                end else begin
                    rep_cnt <= rep_cnt - DAS_ONE;
                end
            end
        end

        assign btn_level[i] = level_q;
        assign btn_press[i] = press_q;
    end

endmodule

// File: doc/tetris_input_ctrl.md
# tetris_input_ctrl

Parametrised player-input front end for the Tetris datapath. Sits between the ADC result, the raw pushbuttons and `tetris_grid`. Converts the joystick ADC sample into a left/centre/right zone with hysteresis, debounces N buttons, and emits single-cycle move/press pulses. Pulses auto-repeat (delayed auto-shift) while a direction or a repeat-enabled button is held. Also drives the zone indicator LEDs.

## Interface
- `ADC_W`, 12, ADC sample width
- `LOW_TH`, 1000, left threshold (enter LEFT when sample < LOW_TH)
- `HIGH_TH`, 2300, right threshold (enter RIGHT when sample > HIGH_TH)
- `HYST`, 100, hysteresis band; legal only if LOW_TH+HYST < HIGH_TH−HYST
- `NUM_BTN`, 2, number of pushbuttons
- `DEBOUNCE_CYC`, 500000, stable cycles required to accept a button change (10 ms at 50 MHz); ≥1
- `DAS_DELAY`, 12500000, cycles from first pulse to first repeat; ≥1
- `DAS_REPEAT`, 2500000, cycles between subsequent repeats; ≥1
- `REPEAT_MASK`, '0, NUM_BTN bits; bit i=1 makes button i auto-repeat
- `clk` in 1: system clock, single clock domain
- `reset` in 1: asynchronous, active-high reset
- `adc_value` in ADC_W: latest joystick sample
- `adc_valid` in 1: one-cycle strobe, `adc_value` is a new sample
- `btn_raw` in NUM_BTN: asynchronous raw buttons, 1 = pressed
- `move_left` out 1: one-cycle move-left pulse
- `move_right` out 1: one-cycle move-right pulse
- `btn_press` out NUM_BTN: one-cycle press pulse per button (repeats if masked)
- `btn_level` out NUM_BTN: debounced button level
- `zone` out 2: 00 CENTER, 01 LEFT, 10 RIGHT (11 never driven)
- `led_red` out 1: high while zone==RIGHT
- `led_green` out 1: high while zone==LEFT

## Operation
- Reset: all outputs 0, zone CENTER, synchronisers, debounce counters and DAS counters cleared. Reset may assert at any cycle; all in-flight repeats are cancelled with no trailing pulse.
- Zone FSM updates only on edges with `adc_valid`=1; unsigned compares at ADC_W bits:
  - CENTER→RIGHT if sample > HIGH_TH; CENTER→LEFT if sample < LOW_TH.
  - RIGHT→LEFT if sample < LOW_TH; RIGHT→CENTER if LOW_TH ≤ sample ≤ HIGH_TH−HYST; otherwise stay.
  - LEFT→RIGHT if sample > HIGH_TH; LEFT→CENTER if LOW_TH+HYST ≤ sample ≤ HIGH_TH; otherwise stay.
- Direction DAS: on entry to LEFT or RIGHT, including a direct LEFT↔RIGHT switch, emit one pulse on the matching output and load the counter with DAS_DELAY. On expiry, emit a pulse and reload with DAS_REPEAT. Leaving to CENTER clears the counter with no pulse. `move_left` and `move_right` are never high together.
- Buttons: each bit passes through a 2-FF synchroniser, then a per-button counter.
  - The counter increments while the synced value ≠ `btn_level[i]` and clears on any equality (a bounce restarts it).
  - When the count reaches DEBOUNCE_CYC, `btn_level[i]` toggles and the counter clears.
  - Rising `btn_level` → one `btn_press[i]` pulse. If REPEAT_MASK[i]=1, DAS runs as above while the level stays high; a falling level cancels it.
- Buttons are independent; simultaneous presses give simultaneous pulses.

## Timing
- Zone, LEDs and the first move pulse are registered on the edge that samples `adc_valid`=1. The pulse is high for exactly the following cycle (latency 1).
- Repeats: first pulse at cycle k, then k+DAS_DELAY, then every DAS_REPEAT cycles.
- Button latency: a clean raw edge yields a `btn_level` change and press pulse 2+DEBOUNCE_CYC cycles after the raw change.
- Samples between strobes are ignored. `adc_valid` held high evaluates every cycle.

## Test plan
Parameters: DEBOUNCE_CYC=4, DAS_DELAY=8, DAS_REPEAT=3, NUM_BTN=2, REPEAT_MASK=2'b10.
- Reset mid-repeat: assert `reset` during the RIGHT repeat stream → all outputs 0 immediately; after release, no pulse until a new sample arrives.
- Threshold and hysteresis: strobes with samples 2301, 2250, 2199 → zone RIGHT, RIGHT, CENTER; one `move_right` pulse total. Then strobe 999 → LEFT, one `move_left` pulse, `led_green`=1.
- Auto-repeat: hold RIGHT via a single strobe of 3000 → `move_right` pulses at k, k+8, k+11, k+14. Then strobe 1500 → zone CENTER, no further pulses.
- Direct switch: zone LEFT mid-delay, then strobe 4095 → zone RIGHT, `move_right` pulses in the next cycle, and the DAS counter restarts at 8.
- Debounce: `btn_raw[0]` toggles 1,0,1 at 2-cycle spacing, then holds 1 → one `btn_press[0]` pulse 6 cycles after the final rise, with no repeat while held.
- Masked repeat: hold `btn_raw[1]`=1 → `btn_press[1]` pulses at k, k+8, k+11; release → `btn_level[1]` falls 6 cycles later and the pulses stop.
